rob_buffer: RTL and testbench
=============================

Name: rob_buffer

Overview:
- Reorder-buffer storage array for the Qu out-of-order core.
- Register file of ROB_DEPTH cells with three independent synchronous write ports and two combinational read ports.
- Typical writers: dispatch (wr1), issue/status update (wr2), writeback/result (wr3). Readers: operand lookup and commit.
- Holds no head/tail pointers; allocation and commit ordering belong to the ROB control logic.

Parameters:
- ROB_DEPTH, default 32 (qu_common::ROB_DEPTH): number of cells; any value from 2 to 2**ROB_ADDR_W.
- ROB_ADDR_W, default 5 (qu_common::ROB_ADDR_W): address width; equals $bits(rob_addr_t).
- ROB_CELL_W, default 64 (qu_common::ROB_CELL_W): cell width; equals $bits(rob_cell_t).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset asserted).
- wr1_en  in  1  write enable, port 1.
- wr1_addr  in  ROB_ADDR_W  write address, port 1 (rob_addr_t).
- wr1_in  in  ROB_CELL_W  write data, port 1 (rob_cell_t).
- wr2_en  in  1  write enable, port 2.
- wr2_addr  in  ROB_ADDR_W  write address, port 2.
- wr2_in  in  ROB_CELL_W  write data, port 2.
- wr3_en  in  1  write enable, port 3.
- wr3_addr  in  ROB_ADDR_W  write address, port 3.
- wr3_in  in  ROB_CELL_W  write data, port 3.
- rd1_addr  in  ROB_ADDR_W  read address, port 1.
- rd1_out  out  ROB_CELL_W  read data, port 1 (rob_cell_t).
- rd2_addr  in  ROB_ADDR_W  read address, port 2.
- rd2_out  out  ROB_CELL_W  read data, port 2.

Behaviour:
- Reset: while rst=0, all cells clear to 0 immediately, independent of clk. rd1_out and rd2_out therefore read 0.
- Reset asserted mid-write: the write is lost; the cell reads 0.
- Writes: on a rising clk edge with rst=1, for each port with wrN_en=1, mem[wrN_addr] <= wrN_in.
  - The new value is visible on the read ports from that edge onward; write latency is 1 cycle.
  - Disabled ports leave the array unchanged.
- Same-address collision in one cycle: priority is wr3 > wr2 > wr1; only the highest-priority enabled port's data is stored.
  - Collisions with identical data are legal and store that value.
- Distinct addresses in one cycle: all enabled writes occur.
- Reads: combinational; rdN_out = mem[rdN_addr], with zero cycles of latency.
  - The two read ports are independent and may use the same address.
- Out of range: any address >= ROB_DEPTH is ignored for writes and reads as 0. No wrap-around or aliasing.
- Same-cycle read of a cell being written returns the old content unless the bypass feature is enabled.
- No handshakes, no full/empty detection, and no internal FSM.

Optional Feature:
- Macro: ROB_RD_BYPASS_EN.
- Defined: each read port forwards same-cycle write data when rdN_addr matches an enabled write address.
  - Forwarding uses the same wr3 > wr2 > wr1 priority.
  - The result is the value the cell will hold after the edge.
- Undefined: reads return stored contents only (old value during the write cycle).

Decomposition:
- qu_common package holds:
  - ROB_DEPTH, ROB_ADDR_W, ROB_CELL_W.
  - typedef rob_addr_t = logic [ROB_ADDR_W-1:0].
  - typedef rob_cell_t = packed struct, ROB_CELL_W bits total: valid(1), ready(1), exception(1), dest_reg(5), value(32), pc-offset/spare(24).
  - Reset value of rob_cell_t is all-zero.
- Sub-module rob_wr_arbiter, optional: per-cell priority select of the three write ports. It is reused by the bypass mux.

Test Plan:
- Reset pulse (rst=0 then 1): rd1_addr=0 and rd2_addr=31 both read 0.
- wr1 addr0=5 for one cycle, then wr2 addr1=6: rd addr0=5 and rd addr1=6 one cycle after each write. wr1_en=0 with wr1_in=5 held changes nothing.
- wr1 and wr2 both target addr2 with 7 in the same cycle: addr2=7.
  - Repeat with wr1=3, wr2=8, wr3=9 all at addr4: addr4=9. Drop wr3: addr4=8.
- rd1_addr=1 and rd2_addr=2 with all writes idle: rd1_out=6, rd2_out=7, stable over multiple cycles.
- wr3 addr5=10: rd addr5=10 after the edge.
  - Same-cycle read: 0 without ROB_RD_BYPASS_EN, 10 with it.
- Assert rst=0 asynchronously between edges after filling addr0..5: all reads drop to 0 before the next clk edge.

Source files
------------

// File: rtl/rob_buffer_pkg.sv
// qu_common: shared ROB sizing and cell/address types for the Qu core.
package qu_common;
  localparam int ROB_DEPTH  = 32;
  localparam int ROB_ADDR_W = 5;
  localparam int ROB_CELL_W = 64;
  typedef logic [ROB_ADDR_W-1:0] rob_addr_t;
  typedef struct packed {
    logic        valid;
    logic        ready;
    logic        exception;
    logic [4:0]  dest_reg;
    logic [31:0] value;
    logic [23:0] spare;
  } rob_cell_t;
  localparam rob_cell_t ROB_CELL_RST = '0;
  function automatic logic addr_in_range(input logic [ROB_ADDR_W:0] addr, input int depth);
    return int'(addr) < depth;
  endfunction
endpackage

// File: rtl/rob_buffer_wr_arbiter.sv
// rob_wr_arbiter: picks the write landing on one address, priority wr3 > wr2 > wr1.
module rob_wr_arbiter #(
  parameter int AW = 5,
  parameter int DW = 64
) (
  input  logic [AW-1:0] sel_addr_i,
  input  logic          wr1_en_i,
  input  logic [AW-1:0] wr1_addr_i,
  input  logic [DW-1:0] wr1_data_i,
  input  logic          wr2_en_i,
  input  logic [AW-1:0] wr2_addr_i,
  input  logic [DW-1:0] wr2_data_i,
  input  logic          wr3_en_i,
  input  logic [AW-1:0] wr3_addr_i,
  input  logic [DW-1:0] wr3_data_i,
  output logic          hit_o,
  output logic [DW-1:0] data_o
);
  logic h1, h2, h3;
  always_comb begin
    h1     = wr1_en_i && (wr1_addr_i == sel_addr_i);
    h2     = wr2_en_i && (wr2_addr_i == sel_addr_i);
    h3     = wr3_en_i && (wr3_addr_i == sel_addr_i);
    hit_o  = h1 | h2 | h3;
    data_o = h3 ? wr3_data_i : h2 ? wr2_data_i : wr1_data_i;
  end
endmodule

// File: rtl/rob_buffer.sv
// rob_buffer: ROB cell array, 3 sync write ports (wr3 > wr2 > wr1), 2 comb read ports.
// Optional same-cycle write-to-read forwarding under ROB_RD_BYPASS_EN.
module rob_buffer import qu_common::*; #(
  parameter int ROB_DEPTH  = qu_common::ROB_DEPTH,
  parameter int ROB_ADDR_W = qu_common::ROB_ADDR_W,
  parameter int ROB_CELL_W = qu_common::ROB_CELL_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr1_en,
  input  logic [ROB_ADDR_W-1:0] wr1_addr,
  input  logic [ROB_CELL_W-1:0] wr1_in,
  input  logic                  wr2_en,
  input  logic [ROB_ADDR_W-1:0] wr2_addr,
  input  logic [ROB_CELL_W-1:0] wr2_in,
  input  logic                  wr3_en,
  input  logic [ROB_ADDR_W-1:0] wr3_addr,
  input  logic [ROB_CELL_W-1:0] wr3_in,
  input  logic [ROB_ADDR_W-1:0] rd1_addr,
  output logic [ROB_CELL_W-1:0] rd1_out,
  input  logic [ROB_ADDR_W-1:0] rd2_addr,
  output logic [ROB_CELL_W-1:0] rd2_out
);
  logic [ROB_CELL_W-1:0] mem_q [ROB_DEPTH];
  logic [ROB_CELL_W-1:0] mem_d [ROB_DEPTH];
  logic [ROB_CELL_W-1:0] wr_data [ROB_DEPTH];
  logic                  wr_hit [ROB_DEPTH];
  logic [ROB_ADDR_W-1:0] rd_addr [2];
  logic [ROB_CELL_W-1:0] rd_data [2];
  // Addresses >= ROB_DEPTH have no cell, so out-of-range writes drop naturally.
  for (genvar c = 0; c < ROB_DEPTH; c++) begin : g_cell
    rob_wr_arbiter #(.AW(ROB_ADDR_W), .DW(ROB_CELL_W)) u_arb (
      .sel_addr_i (ROB_ADDR_W'(c)),
      .wr1_en_i   (wr1_en),
      .wr1_addr_i (wr1_addr),
      .wr1_data_i (wr1_in),
      .wr2_en_i   (wr2_en),
      .wr2_addr_i (wr2_addr),
      .wr2_data_i (wr2_in),
      .wr3_en_i   (wr3_en),
      .wr3_addr_i (wr3_addr),
      .wr3_data_i (wr3_in),
      .hit_o      (wr_hit[c]),
      .data_o     (wr_data[c])
    );
    assign mem_d[c] = wr_hit[c] ? wr_data[c] : mem_q[c];
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) mem_q[c] <= '0;
      else      mem_q[c] <= mem_d[c];
    end
  end
  assign rd_addr[0] = rd1_addr;
  assign rd_addr[1] = rd2_addr;
  for (genvar r = 0; r < 2; r++) begin : g_rd
    logic in_range;
    assign in_range = addr_in_range({1'b0, rd_addr[r]}, ROB_DEPTH);
`ifdef ROB_RD_BYPASS_EN
    logic                  byp_hit;
    logic [ROB_CELL_W-1:0] byp_data;
    rob_wr_arbiter #(.AW(ROB_ADDR_W), .DW(ROB_CELL_W)) u_byp (
      .sel_addr_i (rd_addr[r]),
      .wr1_en_i   (wr1_en),
      .wr1_addr_i (wr1_addr),
      .wr1_data_i (wr1_in),
      .wr2_en_i   (wr2_en),
      .wr2_addr_i (wr2_addr),
      .wr2_data_i (wr2_in),
      .wr3_en_i   (wr3_en),
      .wr3_addr_i (wr3_addr),
      .wr3_data_i (wr3_in),
      .hit_o      (byp_hit),
      .data_o     (byp_data)
    );
    assign rd_data[r] = !in_range ? '0 : byp_hit ? byp_data : mem_q[rd_addr[r]];
`else
    assign rd_data[r] = in_range ? mem_q[rd_addr[r]] : '0;
`endif
  end
  assign rd1_out = rd_data[0];
  assign rd2_out = rd_data[1];
endmodule

// File: tb/tb_rob_buffer.sv
// tb_rob_buffer: directed vector table plus hand sequences for reset, stability and same-cycle reads.
module tb_rob_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr1_en = 1'b0, wr2_en = 1'b0, wr3_en = 1'b0;
  logic [4:0]  wr1_addr = '0, wr2_addr = '0, wr3_addr = '0, rd1_addr = '0, rd2_addr = '0;
  logic [63:0] wr1_in = '0, wr2_in = '0, wr3_in = '0, rd1_out, rd2_out;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rob_buffer dut (
    .clk(clk), .rst(rst),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_in(wr1_in),
    .wr2_en(wr2_en), .wr2_addr(wr2_addr), .wr2_in(wr2_in),
    .wr3_en(wr3_en), .wr3_addr(wr3_addr), .wr3_in(wr3_in),
    .rd1_addr(rd1_addr), .rd1_out(rd1_out),
    .rd2_addr(rd2_addr), .rd2_out(rd2_out)
  );

  typedef struct {
    string       name;
    logic [2:0]  en;
    logic [4:0]  a1, a2, a3;
    logic [63:0] d1, d2, d3;
    logic [4:0]  r1, r2;
    logic [63:0] e1, e2;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_wr();
    wr1_en = 1'b0;
    wr2_en = 1'b0;
    wr3_en = 1'b0;
  endtask

  initial begin
    vecs.push_back('{"wr1_a0",        3'b001, 5'd0,  5'd0,  5'd0,  64'd5, 64'd0,  64'd0,  5'd0,  5'd0,  64'd5,  64'd5});
    vecs.push_back('{"wr2_a1",        3'b010, 5'd0,  5'd1,  5'd0,  64'd0, 64'd6,  64'd0,  5'd0,  5'd1,  64'd5,  64'd6});
    vecs.push_back('{"wr1_disabled",  3'b000, 5'd3,  5'd0,  5'd0,  64'd5, 64'd0,  64'd0,  5'd3,  5'd0,  64'd0,  64'd5});
    vecs.push_back('{"same_data_a2",  3'b011, 5'd2,  5'd2,  5'd0,  64'd7, 64'd7,  64'd0,  5'd2,  5'd2,  64'd7,  64'd7});
    vecs.push_back('{"prio3_a4",      3'b111, 5'd4,  5'd4,  5'd4,  64'd3, 64'd8,  64'd9,  5'd4,  5'd4,  64'd9,  64'd9});
    vecs.push_back('{"prio2_a4",      3'b011, 5'd4,  5'd4,  5'd0,  64'd3, 64'd8,  64'd0,  5'd4,  5'd0,  64'd8,  64'd5});
    vecs.push_back('{"prio3_over1",   3'b101, 5'd10, 5'd0,  5'd10, 64'd3, 64'd0,  64'd4,  5'd10, 5'd10, 64'd4,  64'd4});
    vecs.push_back('{"distinct_7_9",  3'b111, 5'd7,  5'd8,  5'd9,  64'd11, 64'd12, 64'd13, 5'd7,  5'd9,  64'd11, 64'd13});
    vecs.push_back('{"distinct_8",    3'b000, 5'd0,  5'd0,  5'd0,  64'd0, 64'd0,  64'd0,  5'd8,  5'd1,  64'd12, 64'd6});
    vecs.push_back('{"idle_rd_1_2",   3'b000, 5'd1,  5'd2,  5'd4,  64'd99, 64'd99, 64'd99, 5'd1,  5'd2,  64'd6,  64'd7});
    vecs.push_back('{"wr3_a5",        3'b100, 5'd0,  5'd0,  5'd5,  64'd0, 64'd0,  64'd10, 5'd5,  5'd31, 64'd10, 64'd0});
    vecs.push_back('{"wide_a31",      3'b010, 5'd0,  5'd31, 5'd0,  64'd0, 64'hFEDC_BA98_7654_3210, 64'd0, 5'd31, 5'd5, 64'hFEDC_BA98_7654_3210, 64'd10});

    repeat (2) @(negedge clk);
    rd1_addr = 5'd0;
    rd2_addr = 5'd31;
    #1;
    chk("reset_rd1", rd1_out, 64'd0);
    chk("reset_rd2", rd2_out, 64'd0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      {wr3_en, wr2_en, wr1_en} = vecs[i].en;
      wr1_addr = vecs[i].a1; wr2_addr = vecs[i].a2; wr3_addr = vecs[i].a3;
      wr1_in   = vecs[i].d1; wr2_in   = vecs[i].d2; wr3_in   = vecs[i].d3;
      @(posedge clk);
      #1;
      idle_wr();
      rd1_addr = vecs[i].r1;
      rd2_addr = vecs[i].r2;
      #1;
      chk({vecs[i].name, "_rd1"}, rd1_out, vecs[i].e1);
      chk({vecs[i].name, "_rd2"}, rd2_out, vecs[i].e2);
    end

    rd1_addr = 5'd1;
    rd2_addr = 5'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stable_rd1", rd1_out, 64'd6);
      chk("stable_rd2", rd2_out, 64'd7);
    end

    @(negedge clk);
    wr3_en = 1'b1; wr3_addr = 5'd12; wr3_in = 64'd10;
    rd1_addr = 5'd12;
    rd2_addr = 5'd12;
    #1;
`ifdef ROB_RD_BYPASS_EN
    chk("same_cycle_rd1", rd1_out, 64'd10);
    chk("same_cycle_rd2", rd2_out, 64'd10);
`else
    chk("same_cycle_rd1", rd1_out, 64'd0);
    chk("same_cycle_rd2", rd2_out, 64'd0);
`endif
    @(posedge clk);
    #1;
    idle_wr();
    #1;
    chk("after_edge_a12", rd1_out, 64'd10);

    @(negedge clk);
    rd1_addr = 5'd0;
    rd2_addr = 5'd5;
    #1;
    chk("prefill_a0", rd1_out, 64'd5);
    chk("prefill_a5", rd2_out, 64'd10);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_a0", rd1_out, 64'd0);
    chk("async_rst_a5", rd2_out, 64'd0);
    rd1_addr = 5'd4;
    rd2_addr = 5'd2;
    #1;
    chk("async_rst_a4", rd1_out, 64'd0);
    chk("async_rst_a2", rd2_out, 64'd0);

    wr1_en = 1'b1; wr1_addr = 5'd3; wr1_in = 64'd77;
    @(posedge clk);
    #1;
    idle_wr();
    rst = 1'b1;
    rd1_addr = 5'd3;
    #1;
    chk("write_during_rst", rd1_out, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
